dyn_delay_ctrl: RTL and testbench

- Controller plus storage for a runtime-programmable delay line built on a dynamic (addressable-tap) shift register.
- Owns the shift-enable and tap-select of a WIDTH-bit x 2**SELWIDTH-deep shift register and tracks a parallel valid-bit chain.
- Sequences tap changes through a request/acknowledge handshake, either immediately or after a clean flush.
- Sits between a sample producer and a consumer that needs a programmable, glitch-free delay.

---
 rtl/dyn_delay_ctrl.sv | 130 +++++++++++++
 tb/tb_dyn_delay_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dyn_delay_ctrl.sv
// Programmable delay line: WIDTH x 2**SELWIDTH addressable-tap shift register with valid tracking
// and a request/acknowledge tap-change sequencer. Optional sticky overflow flag: DYN_DELAY_OVF_STICKY_EN.
module dyn_delay_ctrl #(
  parameter int SELWIDTH = 5,
  parameter int WIDTH    = 8,
  parameter int RST_SEL  = 0
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [WIDTH-1:0]    DI,
  input  logic                DI_CE,
  output logic                DI_READY,
  output logic [WIDTH-1:0]    DO,
  output logic                DO_VALID,
  input  logic                CFG_REQ,
  input  logic [SELWIDTH-1:0] CFG_SEL,
  input  logic                CFG_MODE,
  output logic                CFG_ACK,
  output logic [SELWIDTH-1:0] SEL_ACT,
  output logic                BUSY
`ifdef DYN_DELAY_OVF_STICKY_EN
  ,
  output logic                OVF
`endif
);

  localparam int DEPTH = 2 ** SELWIDTH;
  localparam logic [SELWIDTH-1:0] SEL_RESET = SELWIDTH'(RST_SEL);
  localparam logic [SELWIDTH-1:0] CNT_LAST  = SELWIDTH'(DEPTH - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t              state;
  logic [WIDTH-1:0]    stage [DEPTH];
  logic [DEPTH-1:0]    vbits;
  logic [SELWIDTH-1:0] sel_act;
  logic [SELWIDTH-1:0] tap_latched;
  logic [SELWIDTH-1:0] flush_cnt;
  logic                cfg_ack;
  logic                busy;
  logic                di_ready;
  logic                push;
  logic                accept;

  assign push   = DI_CE & di_ready;
  // A request is never taken in the ACK cycle, which keeps ACK from ever firing back-to-back.
  assign accept = (state == RUN) & CFG_REQ & ~cfg_ack;

  // Data chain has no reset and only shifts, so it maps onto SRL primitives.
  always_ff @(posedge CLK) begin
    if (push) begin
      stage[0] <= DI;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vbits <= '0;
    end else if (push) begin
      vbits <= {vbits[DEPTH-2:0], 1'b1};
    end else if (state == FLUSH) begin
      vbits <= {vbits[DEPTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= RUN;
      sel_act     <= SEL_RESET;
      tap_latched <= '0;
      flush_cnt   <= '0;
      cfg_ack     <= 1'b0;
      busy        <= 1'b0;
      di_ready    <= 1'b1;
    end else begin
      cfg_ack <= 1'b0;
      case (state)
        RUN: begin
          if (accept) begin
            if (CFG_MODE) begin
              tap_latched <= CFG_SEL;
              flush_cnt   <= '0;
              state       <= FLUSH;
              busy        <= 1'b1;
              di_ready    <= 1'b0;
            end else begin
              sel_act <= CFG_SEL;
              cfg_ack <= 1'b1;
            end
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + SELWIDTH'(1);
          // Last of DEPTH flush cycles: every valid bit has been shifted out by now.
          if (flush_cnt == CNT_LAST) begin
            sel_act  <= tap_latched;
            state    <= RUN;
            busy     <= 1'b0;
            di_ready <= 1'b1;
            cfg_ack  <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef DYN_DELAY_OVF_STICKY_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OVF <= 1'b0;
    end else if (accept && CFG_MODE) begin
      OVF <= 1'b0;
    end else if (DI_CE && !di_ready) begin
      OVF <= 1'b1;
    end
  end
`endif

  assign DI_READY = di_ready;
  assign DO       = stage[sel_act];
  assign DO_VALID = vbits[sel_act];
  assign CFG_ACK  = cfg_ack;
  assign SEL_ACT  = sel_act;
  assign BUSY     = busy;

endmodule

// File: tb/tb_dyn_delay_ctrl.sv
// Directed self-checking bench for dyn_delay_ctrl (SELWIDTH=3, WIDTH=8); inputs change and
// outputs are sampled on the falling edge. OVF checks are compiled in with DYN_DELAY_OVF_STICKY_EN.
module tb_dyn_delay_ctrl;

  localparam int SELWIDTH = 3;
  localparam int WIDTH    = 8;

  logic                CLK;
  logic                RST_N;
  logic [WIDTH-1:0]    DI;
  logic                DI_CE;
  logic                DI_READY;
  logic [WIDTH-1:0]    DO;
  logic                DO_VALID;
  logic                CFG_REQ;
  logic [SELWIDTH-1:0] CFG_SEL;
  logic                CFG_MODE;
  logic                CFG_ACK;
  logic [SELWIDTH-1:0] SEL_ACT;
  logic                BUSY;
`ifdef DYN_DELAY_OVF_STICKY_EN
  logic                OVF;
`endif

  int errors = 0;
  int checks = 0;

  dyn_delay_ctrl #(.SELWIDTH(SELWIDTH), .WIDTH(WIDTH), .RST_SEL(0)) dut (
    .CLK(CLK), .RST_N(RST_N), .DI(DI), .DI_CE(DI_CE), .DI_READY(DI_READY),
    .DO(DO), .DO_VALID(DO_VALID), .CFG_REQ(CFG_REQ), .CFG_SEL(CFG_SEL),
    .CFG_MODE(CFG_MODE), .CFG_ACK(CFG_ACK), .SEL_ACT(SEL_ACT), .BUSY(BUSY)
`ifdef DYN_DELAY_OVF_STICKY_EN
    , .OVF(OVF)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic applyStimulus(input logic [7:0] di, input logic ce, input logic req,
                               input logic [2:0] sel, input logic mode);
    DI       = di;
    DI_CE    = ce;
    CFG_REQ  = req;
    CFG_SEL  = sel;
    CFG_MODE = mode;
    stepCycle();
  endtask

  // Steps while BUSY is high, bounded so a stuck flush is reported instead of hanging.
  task automatic waitFlushEnd(output int n);
    n = 0;
    while (BUSY === 1'b1 && n < 40) begin
      n++;
      stepCycle();
    end
  endtask

  logic [7:0] exp2 [8];
  int n;

  initial begin
    exp2 = '{8'h06, 8'h07, 8'h08, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    RST_N = 1'b0;
    DI = '0; DI_CE = 1'b0; CFG_REQ = 1'b0; CFG_SEL = '0; CFG_MODE = 1'b0;
    @(negedge CLK);
    @(negedge CLK);

    // 1: reset state, then zero-tap pass-through
    checkOutput("rst_do_valid", DO_VALID, 0);
    checkOutput("rst_sel_act", SEL_ACT, 0);
    checkOutput("rst_busy", BUSY, 0);
    checkOutput("rst_di_ready", DI_READY, 1);
    checkOutput("rst_ack", CFG_ACK, 0);
`ifdef DYN_DELAY_OVF_STICKY_EN
    checkOutput("rst_ovf", OVF, 0);
`endif
    RST_N = 1'b1;
    stepCycle();
    checkOutput("t1_valid_before_push", DO_VALID, 0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(8'(i), 1'b1, 1'b0, 3'd0, 1'b0);
      checkOutput("t1_do", DO, 32'(i));
      checkOutput("t1_valid", DO_VALID, 1);
    end
    DI_CE = 1'b0;

    // 2: immediate retarget to tap 3
    applyStimulus(8'h00, 1'b0, 1'b1, 3'd3, 1'b0);
    checkOutput("t2_ack", CFG_ACK, 1);
    checkOutput("t2_sel", SEL_ACT, 3);
    applyStimulus(8'h00, 1'b0, 1'b0, 3'd3, 1'b0);
    checkOutput("t2_ack_low", CFG_ACK, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(8'(8'h10 + i), 1'b1, 1'b0, 3'd3, 1'b0);
      checkOutput("t2_do", DO, 32'(exp2[i]));
    end

    // 3: flush-then-apply to tap 5 with pushes held on (first push lands on the accept edge)
    applyStimulus(8'hAA, 1'b1, 1'b1, 3'd5, 1'b1);
    checkOutput("t3_busy", BUSY, 1);
    checkOutput("t3_di_ready", DI_READY, 0);
    CFG_SEL  = 3'd1;
    CFG_MODE = 1'b0;
    waitFlushEnd(n);
    checkOutput("t3_flush_cycles", 32'(n), 8);
    checkOutput("t3_ack", CFG_ACK, 1);
    checkOutput("t3_sel", SEL_ACT, 5);
    checkOutput("t3_do_valid", DO_VALID, 0);
    checkOutput("t3_di_ready_back", DI_READY, 1);
`ifdef DYN_DELAY_OVF_STICKY_EN
    checkOutput("t3_ovf", OVF, 1);
`endif
    applyStimulus(8'h00, 1'b0, 1'b0, 3'd5, 1'b0);
    checkOutput("t3_ack_low", CFG_ACK, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'(8'h20 + i), 1'b1, 1'b0, 3'd5, 1'b0);
      checkOutput("t3_not_yet_valid", DO_VALID, 0);
    end
    applyStimulus(8'h25, 1'b1, 1'b0, 3'd5, 1'b0);
    checkOutput("t3_do_delayed", DO, 32'h20);
    checkOutput("t3_valid_delayed", DO_VALID, 1);

    // 4: push and retarget on the same edge, then same-tap request with REQ left high in ACK cycle
    applyStimulus(8'h30, 1'b1, 1'b1, 3'd2, 1'b0);
    checkOutput("t4_ack", CFG_ACK, 1);
    checkOutput("t4_sel", SEL_ACT, 2);
    checkOutput("t4_do", DO, 32'h24);
    checkOutput("t4_valid", DO_VALID, 1);
    applyStimulus(8'h00, 1'b0, 1'b0, 3'd2, 1'b0);
    checkOutput("t4_ack_low", CFG_ACK, 0);
    applyStimulus(8'h00, 1'b0, 1'b1, 3'd2, 1'b0);
    checkOutput("t4_same_ack", CFG_ACK, 1);
    checkOutput("t4_same_sel", SEL_ACT, 2);
    stepCycle();
    checkOutput("t4_no_double_ack", CFG_ACK, 0);
    CFG_REQ = 1'b0;
    stepCycle();
    checkOutput("t4_ack_idle", CFG_ACK, 0);

    // 5: reset during the fourth flush cycle
    applyStimulus(8'h00, 1'b0, 1'b1, 3'd6, 1'b1);
    checkOutput("t5_busy", BUSY, 1);
    for (int i = 0; i < 3; i++) stepCycle();
    checkOutput("t5_still_busy", BUSY, 1);
    RST_N = 1'b0;
    #1;
    checkOutput("t5_sel", SEL_ACT, 0);
    checkOutput("t5_busy_clr", BUSY, 0);
    checkOutput("t5_do_valid", DO_VALID, 0);
    checkOutput("t5_di_ready", DI_READY, 1);
    @(negedge CLK);
    CFG_REQ = 1'b0;
    RST_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      checkOutput("t5_no_ack", CFG_ACK, 0);
      checkOutput("t5_no_busy", BUSY, 0);
    end

`ifdef DYN_DELAY_OVF_STICKY_EN
    // 6: dropped pushes during flush set OVF; it survives the flush and the next flush request clears it
    applyStimulus(8'h00, 1'b0, 1'b1, 3'd4, 1'b1);
    checkOutput("t6_ovf_clear_start", OVF, 0);
    applyStimulus(8'h55, 1'b1, 1'b1, 3'd4, 1'b1);
    checkOutput("t6_ovf_set", OVF, 1);
    DI_CE = 1'b0;
    waitFlushEnd(n);
    checkOutput("t6_flush_cycles", 32'(n), 7);
    checkOutput("t6_ack", CFG_ACK, 1);
    checkOutput("t6_ovf_held", OVF, 1);
    applyStimulus(8'h00, 1'b0, 1'b0, 3'd4, 1'b0);
    checkOutput("t6_ovf_still", OVF, 1);
    applyStimulus(8'h00, 1'b0, 1'b1, 3'd1, 1'b1);
    checkOutput("t6_ovf_cleared", OVF, 0);
    waitFlushEnd(n);
    checkOutput("t6_ack2", CFG_ACK, 1);
    CFG_REQ = 1'b0;
    stepCycle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
